// File: rtl/gyro_serdes_pkg.sv
// Shared types, defaults and sizing helpers for the gyro frame serdes.
package gyro_serdes_pkg;

  localparam int unsigned NchDefault  = 3;
  localparam int unsigned WdDefault   = 16;
  localparam int unsigned DivwDefault = 4;
  localparam int unsigned DpwrDefault = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_e;

  function automatic int unsigned frame_bits(int unsigned nch, int unsigned wd);
    return nch * wd;
  endfunction

  function automatic int unsigned cnt_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gyro_frame_serdes_if.sv
// Frame-side stream bundle between the channel IP FIFOs and the serdes.
interface gyro_frame_serdes_if
  import gyro_serdes_pkg::*;
#(
  parameter int unsigned NCH = NchDefault,
  parameter int unsigned WD  = WdDefault
);

  logic [NCH*WD-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [WD-1:0]     rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              rx_last;
  logic              rx_overflow;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid, rx_last, rx_overflow
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid, rx_last, rx_overflow
  );

endinterface

// File: rtl/gyro_rx_word_fifo.sv
// Synchronous word FIFO; entries live in flops and the head is driven from them.
module gyro_rx_word_fifo #(
  parameter int unsigned Width = 17,
  parameter int unsigned Dpwr  = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned Depth = 2 ** Dpwr;
  localparam int unsigned Cw    = Dpwr + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [Dpwr-1:0]  wr_ptr_q, rd_ptr_q;
  logic [Cw-1:0]    count_q;
  logic             do_push, do_pop;

  assign full    = count_q == Cw'(Depth);
  assign empty   = count_q == '0;
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + Cw'(do_push) - Cw'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/gyro_frame_serdes.sv
// Gyro serial channel: MCK/DSYNC generation, frame TX shifter, RX deserialiser with word FIFO.
// Optional GYRO_SERDES_DROP_CNT_EN adds a saturating dropped-word counter output.
module gyro_frame_serdes
  import gyro_serdes_pkg::*;
#(
  parameter int unsigned NCH  = NchDefault,
  parameter int unsigned WD   = WdDefault,
  parameter int unsigned DIVW = DivwDefault,
  parameter int unsigned DPWR = DpwrDefault
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            enable,
  input  logic            tx_start_stop,
  input  logic            rx_start_stop,
  input  logic            loopback,
  input  logic [DIVW-1:0] clk_div,
  input  logic            debug_clear,
  gyro_frame_serdes_if.slave bus,
  output logic            DTX,
  output logic            DSYNC,
  input  logic            DRX,
  output logic            MCK
`ifdef GYRO_SERDES_DROP_CNT_EN
  ,
  output logic [15:0]     rx_drop_count
`endif
);

  localparam int unsigned FB  = frame_bits(NCH, WD);
  localparam int unsigned BCW = cnt_width(FB);
  localparam logic [BCW-1:0] LastBit = BCW'(FB - 1);

  // Clock-enable divider and free-running frame bit counter.
  logic [DIVW-1:0] div_cnt_q;
  logic            half_q;
  logic            tick, fall, rise;
  logic [BCW-1:0]  bit_cnt_q;
  logic            frame_last, boundary;

  assign tick       = div_cnt_q >= clk_div;
  assign fall       = tick & half_q;
  assign rise       = tick & ~half_q;
  assign frame_last = bit_cnt_q == LastBit;
  assign boundary   = fall & frame_last;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
      half_q    <= 1'b0;
      bit_cnt_q <= '0;
    end else begin
      div_cnt_q <= tick ? '0 : div_cnt_q + 1'b1;
      if (tick) half_q <= ~half_q;
      if (fall) bit_cnt_q <= frame_last ? '0 : bit_cnt_q + 1'b1;
    end
  end

  assign MCK   = half_q & enable;
  assign DSYNC = frame_last & enable;

  // TX frame FSM.
  tx_state_e      state_q, state_d;
  logic [FB-1:0]  shift_q, shift_d;
  logic           tx_ready_int, tx_fire, dtx_int;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    tx_ready_int = boundary & tx_start_stop & enable;
    tx_fire      = tx_ready_int & bus.tx_valid;
    if (tx_fire) begin
      state_d = SHIFT;
      shift_d = bus.tx_data;
    end else if (state_q == SHIFT && fall) begin
      shift_d = shift_q << 1;
      if (boundary) state_d = IDLE;
    end
  end

  assign bus.tx_ready = tx_ready_int;
  assign dtx_int      = shift_q[FB-1] & (state_q == SHIFT) & enable;
  assign DTX          = dtx_int;

  // RX deserialiser: sample mid-bit, push the finished word one clock later.
  logic [WD-1:0] rx_sr_q;
  logic          word_done_q, word_last_q;
  logic          rx_bit, word_end;
  logic          rx_push, rx_pop, rx_drop;
  logic          fifo_full, fifo_empty;
  logic [WD:0]   fifo_head;
  logic          overflow_q;

  assign rx_bit   = loopback ? dtx_int : DRX;
  assign word_end = (32'(bit_cnt_q) % WD) == WD - 1;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rx_sr_q     <= '0;
      word_done_q <= 1'b0;
      word_last_q <= 1'b0;
    end else begin
      word_done_q <= rise & word_end;
      if (rise) begin
        rx_sr_q     <= {rx_sr_q[WD-2:0], rx_bit};
        word_last_q <= frame_last;
      end
    end
  end

  assign rx_push = word_done_q & rx_start_stop;
  assign rx_pop  = bus.rx_ready & ~fifo_empty;
  assign rx_drop = rx_push & fifo_full & ~rx_pop;

  gyro_rx_word_fifo #(
    .Width (WD + 1),
    .Dpwr  (DPWR)
  ) u_rx_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (rx_push),
    .wdata   ({word_last_q, rx_sr_q}),
    .pop     (bus.rx_ready),
    .rdata   (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign bus.rx_valid = ~fifo_empty;
  assign bus.rx_data  = fifo_head[WD-1:0];
  assign bus.rx_last  = fifo_head[WD];

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
    end else if (rx_drop) begin
      overflow_q <= 1'b1;
    end else if (debug_clear) begin
      overflow_q <= 1'b0;
    end
  end

  assign bus.rx_overflow = overflow_q;

`ifdef GYRO_SERDES_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      drop_cnt_q <= '0;
    end else if (debug_clear) begin
      drop_cnt_q <= {15'd0, rx_drop};
    end else if (rx_drop && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign rx_drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_gyro_frame_serdes.sv
// Self-checking bench for gyro_frame_serdes: loopback frames against a frame-level reference model.
module tb_gyro_frame_serdes;

  localparam int unsigned NCH  = 3;
  localparam int unsigned WD   = 16;
  localparam int unsigned DIVW = 4;
  localparam int unsigned DPWR = 2;
  localparam int unsigned FB   = NCH * WD;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            enable = 1'b0;
  logic            tx_start_stop = 1'b0;
  logic            rx_start_stop = 1'b0;
  logic            loopback = 1'b0;
  logic [DIVW-1:0] clk_div = '0;
  logic            debug_clear = 1'b0;
  logic            DTX, DSYNC, MCK;
  logic            DRX = 1'b0;
`ifdef GYRO_SERDES_DROP_CNT_EN
  logic [15:0]     rx_drop_count;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  gyro_frame_serdes_if #(.NCH(NCH), .WD(WD)) bus ();

  gyro_frame_serdes #(
    .NCH  (NCH),
    .WD   (WD),
    .DIVW (DIVW),
    .DPWR (DPWR)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .enable        (enable),
    .tx_start_stop (tx_start_stop),
    .rx_start_stop (rx_start_stop),
    .loopback      (loopback),
    .clk_div       (clk_div),
    .debug_clear   (debug_clear),
    .bus           (bus),
    .DTX           (DTX),
    .DSYNC         (DSYNC),
    .DRX           (DRX),
    .MCK           (MCK)
`ifdef GYRO_SERDES_DROP_CNT_EN
    ,
    .rx_drop_count (rx_drop_count)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Monitors sample on the falling edge, away from the active edge.
  logic [WD:0] rx_q[$];
  int          rdy_q[$];
  always @(negedge clock) begin
    if (reset_n && bus.rx_valid && bus.rx_ready) rx_q.push_back({bus.rx_last, bus.rx_data});
    if (bus.tx_ready) rdy_q.push_back(cyc);
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout observed no finish required finish");
    $fatal(1, "timeout");
  end

  // Reference model state: frames expected back, in order.
  logic [FB-1:0] exp_q[$];
  logic [FB-1:0] got_q[$];
  int            got_idx[$];
  int            lastflag_bad;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FB-1:0] rnd_frame();
    logic [FB-1:0] f = '0;
    for (int i = 0; i < NCH; i++) f = (f << WD) | FB'(WD'($urandom));
    return f | FB'(1);
  endfunction

  // Frame period in clocks: FB bits, each 2*(clk_div+1) clocks.
  function automatic int frame_clocks();
    return 2 * FB * (int'(clk_div) + 1);
  endfunction

  task automatic wait_ready(input string tag);
    bit ok = 0;
    for (int i = 0; i < frame_clocks() + 8; i++) begin
      if (bus.tx_ready) begin
        ok = 1;
        break;
      end
      tick();
    end
    check({tag, " ready_seen"}, 64'(ok), 64'd1);
  endtask

  // Handshake a frame; leaves tx_valid high so the caller can chain another.
  task automatic send(input string tag, input logic [FB-1:0] f);
    bus.tx_data  = f;
    bus.tx_valid = 1'b1;
    wait_ready(tag);
    tick();
    check({tag, " ready_pulse"}, 64'(bus.tx_ready), 64'd0);
  endtask

  // Group the received stream into frames, starting after the first end-of-frame marker.
  task automatic analyse();
    int k = 0;
    int triple = 0;
    logic [FB-1:0] acc;
    got_q.delete();
    got_idx.delete();
    lastflag_bad = 0;
    while (k < rx_q.size() && !rx_q[k][WD]) k++;
    k++;
    while (k + NCH <= rx_q.size()) begin
      acc = '0;
      for (int w = 0; w < NCH; w++) begin
        acc = (acc << WD) | FB'(rx_q[k+w][WD-1:0]);
        if (rx_q[k+w][WD] != (w == NCH - 1)) lastflag_bad++;
      end
      if (acc != '0) begin
        got_q.push_back(acc);
        got_idx.push_back(triple);
      end
      triple++;
      k += NCH;
    end
  endtask

  task automatic verify(input string tag, input bit contig);
    analyse();
    check({tag, " lastflags"}, 64'(lastflag_bad), 64'd0);
    check({tag, " frame_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s frame%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
      if (contig && i > 0)
        check($sformatf("%s gap%0d", tag, i), 64'(got_idx[i] - got_idx[i-1]), 64'd1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " DTX"}, 64'(DTX), 64'd0);
    check({tag, " DSYNC"}, 64'(DSYNC), 64'd0);
    check({tag, " MCK"}, 64'(MCK), 64'd0);
    check({tag, " tx_ready"}, 64'(bus.tx_ready), 64'd0);
    check({tag, " rx_valid"}, 64'(bus.rx_valid), 64'd0);
    check({tag, " rx_last"}, 64'(bus.rx_last), 64'd0);
    check({tag, " rx_overflow"}, 64'(bus.rx_overflow), 64'd0);
    check({tag, " rx_data"}, 64'(bus.rx_data), 64'd0);
  endtask

  initial begin
    logic [FB-1:0] f1, f2;
    int ds_cnt, mck_cnt, dtx_cnt, r0, r1, n;
    logic prev_ds;

    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b1;
    tick(3);
    check_reset_outputs("reset");

    // Idle line timing at the fastest divider.
    reset_n = 1'b1;
    enable = 1'b1;
    tx_start_stop = 1'b1;
    rx_start_stop = 1'b1;
    loopback = 1'b1;
    ds_cnt = 0; mck_cnt = 0; dtx_cnt = 0; r0 = -1; r1 = -1; prev_ds = 1'b0;
    for (int i = 0; i < 288; i++) begin
      tick();
      ds_cnt += int'(DSYNC);
      mck_cnt += int'(MCK);
      dtx_cnt += int'(DTX);
      if (DSYNC && !prev_ds) begin
        if (r0 < 0) r0 = i;
        else if (r1 < 0) r1 = i;
      end
      prev_ds = DSYNC;
    end
    check("idle dsync_high", 64'(ds_cnt), 64'd6);
    check("idle mck_high", 64'(mck_cnt), 64'd144);
    check("idle dtx_high", 64'(dtx_cnt), 64'd0);
    check("idle dsync_period", 64'(r1 - r0), 64'(2 * FB));

    // Directed loopback frame.
    rx_q.delete();
    exp_q.delete();
    f1 = {16'hA5A5, 16'h1234, 16'hFFFF};
    exp_q.push_back(f1);
    send("directed", f1);
    bus.tx_valid = 1'b0;
    tick(frame_clocks() + 10);
    verify("directed", 1'b0);

    // Back-to-back frames at clk_div=3.
    clk_div = 4'd3;
    rx_q.delete();
    exp_q.delete();
    rdy_q.delete();
    f1 = rnd_frame();
    f2 = rnd_frame();
    exp_q.push_back(f1);
    exp_q.push_back(f2);
    send("b2b f1", f1);
    send("b2b f2", f2);
    bus.tx_valid = 1'b0;
    tick(frame_clocks() + 10);
    check("b2b ready_spacing", 64'(rdy_q[1] - rdy_q[0]), 64'(frame_clocks()));
    verify("b2b", 1'b1);

    // Randomised frames, divider and gaps.
    clk_div = DIVW'($urandom_range(0, 2));
    rx_q.delete();
    exp_q.delete();
    for (int f = 0; f < 4; f++) begin
      f1 = rnd_frame();
      exp_q.push_back(f1);
      send($sformatf("rand f%0d", f), f1);
      if ($urandom_range(0, 1) == 1) begin
        bus.tx_valid = 1'b0;
        tick($urandom_range(0, 150));
      end
    end
    bus.tx_valid = 1'b0;
    tick(frame_clocks() + 10);
    verify("rand", 1'b0);

    // Overflow: six words into a four-entry FIFO with no pops.
    clk_div = '0;
    rx_start_stop = 1'b0;
    tick(10);
    bus.rx_ready = 1'b0;
    rx_q.delete();
    f1 = rnd_frame();
    f2 = rnd_frame();
    bus.tx_data  = f1;
    bus.tx_valid = 1'b1;
    wait_ready("ovf f1");
    tick();
    rx_start_stop = 1'b1;
    bus.tx_data = f2;
    wait_ready("ovf f2");
    tick();
    bus.tx_valid = 1'b0;
    wait_ready("ovf end");
    tick();
    rx_start_stop = 1'b0;
    check("ovf overflow", 64'(bus.rx_overflow), 64'd1);
    check("ovf rx_valid", 64'(bus.rx_valid), 64'd1);
`ifdef GYRO_SERDES_DROP_CNT_EN
    check("ovf drop_count", 64'(rx_drop_count), 64'd2);
`endif
    bus.rx_ready = 1'b1;
    tick(8);
    check("ovf held_words", 64'(rx_q.size()), 64'd4);
    check("ovf word0", 64'(rx_q[0]), 64'({1'b0, f1[47:32]}));
    check("ovf word1", 64'(rx_q[1]), 64'({1'b0, f1[31:16]}));
    check("ovf word2", 64'(rx_q[2]), 64'({1'b1, f1[15:0]}));
    check("ovf word3", 64'(rx_q[3]), 64'({1'b0, f2[47:32]}));
    debug_clear = 1'b1;
    tick();
    debug_clear = 1'b0;
    check("ovf cleared", 64'(bus.rx_overflow), 64'd0);
`ifdef GYRO_SERDES_DROP_CNT_EN
    check("ovf count_cleared", 64'(rx_drop_count), 64'd0);
`endif
    rx_start_stop = 1'b1;

    // One-clock reset in the middle of a frame.
    send("rst frame", rnd_frame());
    bus.tx_valid = 1'b0;
    tick(20);
    reset_n = 1'b0;
    tick();
    check_reset_outputs("midreset");
    reset_n = 1'b1;
    n = 0;
    while (!bus.tx_ready && n < 400) begin
      tick();
      n++;
    end
    check("midreset next_boundary", 64'(n), 64'(frame_clocks() - 1));
    tick(frame_clocks() + 10);

    // Drop tx_start_stop at bit 10: frame completes, nothing further is loaded.
    rx_q.delete();
    exp_q.delete();
    f1 = rnd_frame();
    exp_q.push_back(f1);
    send("stop", f1);
    bus.tx_data = rnd_frame();
    tick(20);
    tx_start_stop = 1'b0;
    rdy_q.delete();
    ds_cnt = 0;
    for (int i = 0; i < 192; i++) begin
      tick();
      ds_cnt += int'(DSYNC);
    end
    check("stop ready_pulses", 64'(rdy_q.size()), 64'd0);
    check("stop dsync_high", 64'(ds_cnt), 64'd4);
    verify("stop", 1'b0);
    bus.tx_valid = 1'b0;
    tx_start_stop = 1'b1;

    // Pins disabled: outputs held low and no handshake.
    enable = 1'b0;
    bus.tx_valid = 1'b1;
    rdy_q.delete();
    ds_cnt = 0; mck_cnt = 0; dtx_cnt = 0;
    for (int i = 0; i < 192; i++) begin
      tick();
      ds_cnt += int'(DSYNC);
      mck_cnt += int'(MCK);
      dtx_cnt += int'(DTX);
    end
    check("disable dsync", 64'(ds_cnt), 64'd0);
    check("disable mck", 64'(mck_cnt), 64'd0);
    check("disable dtx", 64'(dtx_cnt), 64'd0);
    check("disable ready", 64'(rdy_q.size()), 64'd0);
    bus.tx_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
